// File: rtl/fmul_pkg.sv
// Shared types and constants for the float-multiplier sharing arbiter.
package fmul_pkg;

  localparam int FP_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_e;

  localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] FP_TWO  = 32'h4000_0000;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fmul_tag_fifo.sv
// Synchronous tag FIFO holding the requester ID of every operation in flight.
module fmul_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: storage carries no reset; validity is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fmul_share_arb.sv
// Round-robin sharing of one AXI-Stream float multiplier between NUM_REQ requesters.
// Optional per-requester grant/stall counters are built when FMUL_SHARE_ARB_STATS_EN is defined.
module fmul_share_arb
  import fmul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MAX_OUT = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a_data,
  input  logic [NUM_REQ*FP_W-1:0] req_b_data,
  output logic                    fm_a_tvalid,
  input  logic                    fm_a_tready,
  output logic [FP_W-1:0]         fm_a_tdata,
  output logic                    fm_b_tvalid,
  input  logic                    fm_b_tready,
  output logic [FP_W-1:0]         fm_b_tdata,
  input  logic                    fm_res_tvalid,
  output logic                    fm_res_tready,
  input  logic [FP_W-1:0]         fm_res_tdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
`ifdef FMUL_SHARE_ARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NUM_REQ*16-1:0]   stat_grant,
  output logic [NUM_REQ*16-1:0]   stat_stall
`endif
);

  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  arb_state_e        state, state_nxt;
  logic [ID_W-1:0]   rr_ptr;
  logic [FP_W-1:0]   issue_a, issue_b;
  logic [ID_W-1:0]   issue_id;
  logic              a_done, b_done, a_done_nxt, b_done_nxt;
  logic              a_fin, b_fin;
  logic              can_grant;
  logic              tag_push, tag_pop;
  logic              fifo_full, fifo_empty;
  logic [ID_W-1:0]   fifo_head;
  logic [CNT_W-1:0]  outstanding;

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  logic              pick_any, hi_any;
  logic [ID_W-1:0]   hi_id, lo_id, grant_id;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    pick_any = 1'b0;
    hi_any   = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        pick_any = 1'b1;
        lo_id    = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
    grant_id = hi_any ? hi_id : lo_id;
  end

  always_comb begin
    state_nxt   = state;
    a_done_nxt  = a_done;
    b_done_nxt  = b_done;
    tag_push    = 1'b0;
    can_grant   = 1'b0;
    fm_a_tvalid = 1'b0;
    fm_b_tvalid = 1'b0;
    a_fin       = a_done | fm_a_tready;
    b_fin       = b_done | fm_b_tready;
    case (state)
      IDLE: begin
        if (pick_any && !fifo_full) begin
          can_grant = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        fm_a_tvalid = !a_done;
        fm_b_tvalid = !b_done;
        if (a_fin && b_fin) begin
          tag_push   = 1'b1;
          a_done_nxt = 1'b0;
          b_done_nxt = 1'b0;
          state_nxt  = IDLE;
        end else begin
          a_done_nxt = a_fin;
          b_done_nxt = b_fin;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req_ready = can_grant ? (NUM_REQ'(1) << grant_id) : '0;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      issue_a  <= '0;
      issue_b  <= '0;
      issue_id <= '0;
      a_done   <= 1'b0;
      b_done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_done <= a_done_nxt;
      b_done <= b_done_nxt;
      if (can_grant) begin
        issue_a  <= req_a_data[grant_id*FP_W +: FP_W];
        issue_b  <= req_b_data[grant_id*FP_W +: FP_W];
        issue_id <= grant_id;
        rr_ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign fm_a_tdata = issue_a;
  assign fm_b_tdata = issue_b;

  // The FIFO occupancy is the count of operations issued but not yet answered.
  fmul_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (aclk),
    .rst_n     (aresetn),
    .push      (tag_push),
    .push_data (issue_id),
    .pop       (tag_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (outstanding)
  );

  assign rsp_valid     = fm_res_tvalid & !fifo_empty;
  assign fm_res_tready = rsp_ready & !fifo_empty;
  assign tag_pop       = fm_res_tvalid & rsp_ready & !fifo_empty;
  assign rsp_data      = fm_res_tdata;
  assign rsp_id        = fifo_empty ? '0 : fifo_head;
  assign busy          = (state == ISSUE) || (outstanding != '0);

  // A result with no tag behind it was never issued by this block.
  a_no_orphan_result: assert property (@(posedge aclk) disable iff (!aresetn)
    !(fm_res_tvalid && fifo_empty));

`ifdef FMUL_SHARE_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_cnt, stall_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else if (stat_clr) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i] && grant_cnt[i] != 16'hFFFF)
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        if (req_valid[i] && !req_ready[i] && stall_cnt[i] != 16'hFFFF)
          stall_cnt[i] <= stall_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_grant = grant_cnt;
  assign stat_stall = stall_cnt;
`endif

endmodule

// File: doc/fmul_share_arb.md
Name: fmul_share_arb

Overview:
- Shares one AXI-Stream single-precision float multiplier (a/b operand channels, one result channel) between NUM_REQ requesters, e.g. FFT butterfly lanes.
- Round-robin arbitration; each issued operation is tagged with its requester ID.
- Results return in order on one response stream carrying the ID.
- Sits between the butterfly datapath and the multiplier wrapper.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester ID width, equal to clog2(NUM_REQ).
- MAX_OUT, 16: maximum in-flight operations and tag FIFO depth (power of 2, at least multiplier latency + 2).

Ports:
- aclk  in  1  clock; all logic rising-edge.
- aresetn  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand pair valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a_data  in  NUM_REQ*32  operand A, lane i at bits [32i+31:32i].
- req_b_data  in  NUM_REQ*32  operand B, same packing.
- fm_a_tvalid / fm_a_tready / fm_a_tdata  out/in/out  1/1/32  multiplier A channel.
- fm_b_tvalid / fm_b_tready / fm_b_tdata  out/in/out  1/1/32  multiplier B channel.
- fm_res_tvalid / fm_res_tready / fm_res_tdata  in/out/in  1/1/32  multiplier result channel.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response ready.
- rsp_data  out  32  product.
- rsp_id  out  ID_W  requester that issued the operation.
- busy  out  1  issue register loaded or tags outstanding.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; tag FIFO empty; outstanding=0; state IDLE.
- State IDLE:
  - If any req_valid is set and outstanding < MAX_OUT, grant the first set requester at or after rr_ptr, wrapping around.
  - req_ready[g]=1 combinationally in that cycle only; grant depends on req_valid but never on req_ready.
  - Operands and g are captured into the issue register; next state is ISSUE; rr_ptr <= g+1 mod NUM_REQ.
- State ISSUE:
  - fm_a_tvalid = !a_done; fm_b_tvalid = !b_done; tdata comes from the issue register and is held stable.
  - a_done/b_done set on the respective handshake.
  - When both channels have completed (same cycle or different cycles): push g to the tag FIFO, outstanding++, clear the done flags, go to IDLE.
  - New grant earliest the following cycle; peak throughput is one operation per 2 cycles.
- Latency: req handshake in cycle N gives fm_*_tvalid=1 in cycle N+1.
- Response path, combinational pass-through:
  - rsp_valid = fm_res_tvalid & !fifo_empty.
  - fm_res_tready = rsp_ready & !fifo_empty.
  - rsp_data = fm_res_tdata; rsp_id = FIFO head.
  - On rsp handshake: pop the FIFO and decrement outstanding.
- Simultaneous issue push and response pop: outstanding unchanged; FIFO pointers both advance.
- Full (outstanding==MAX_OUT): no grant, all req_ready=0; the in-progress ISSUE still completes.
- Result arriving with tag FIFO empty: not consumed (fm_res_tready=0); protocol violation, flagged by assertion in simulation.
- rsp_ready=0 stalls the multiplier output. The issue side keeps issuing until the FIFO is full.
- Reset mid-operation: issue register, flags and FIFO cleared asynchronously. The multiplier shares aresetn, so in-flight results are discarded.
- busy = (state==ISSUE) | (outstanding!=0).

Optional Feature:
- FMUL_SHARE_ARB_STATS_EN defined:
  - Adds a per-requester 16-bit saturating grant counter and a 16-bit saturating stall counter (req_valid set but no grant).
  - Both counters are exposed on output ports stat_grant (NUM_REQ*16) and stat_stall (NUM_REQ*16).
  - Counters are cleared by reset or by input stat_clr (synchronous, wins over increment).
- Undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fmul_pkg:
  - FP_W=32.
  - Arbiter state enum {IDLE, ISSUE}.
  - Canonical constants FP_ONE=0x3F800000, FP_TWO=0x40000000, FP_ZERO=0x00000000.
- Sub-module: fmul_tag_fifo.
  - Synchronous FIFO, width ID_W, depth MAX_OUT.
  - Provides push/pop/full/empty/count; write-first on simultaneous push/pop when not empty.

Test Plan:
- Single op: req0 a=0x40400000 (3.0), b=0x40000000 (2.0) -> fm_a/b_tvalid asserted next cycle; rsp_data=0x40C00000 (6.0), rsp_id=0.
- Round robin: all 4 req_valid held for 8 grants -> grant order 0,1,2,3,0,1,2,3; rsp_id sequence identical.
- Skewed operand accept: fm_b_tready low 3 cycles after fm_a handshake -> A not re-sent; one tag pushed; exactly one result; the next grant only after the B handshake.
- Backpressure/full: rsp_ready=0, continuous requests -> exactly MAX_OUT=16 issues, then req_ready stays 0; release rsp_ready -> 16 responses in order, issuing resumes.
- Async reset asserted mid-ISSUE with 5 ops outstanding -> all outputs 0 immediately; after release, first grant goes to req0 (rr_ptr=0); busy=0.
- Stats (macro defined): req1 blocked 3 cycles, then granted -> stat_stall[1]=3, stat_grant[1]=1; pulse stat_clr -> both 0.
